// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser, per-channel debounce, level plus press/release strobes.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press strobes while a button stays held.
module btn_conditioner #(
    parameter int BTN_NUM         = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic               clk100_i,
    input  logic               rst_i,
    input  logic [BTN_NUM-1:0] btn_n_i,
    output logic [BTN_NUM-1:0] level_o,
    output logic [BTN_NUM-1:0] press_o,
    output logic [BTN_NUM-1:0] release_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1))
    begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY || longint'(REPEAT_DELAY) > (longint'(1) << 27))
    begin : g_bad_repeat
        $error("btn_conditioner: REPEAT_DELAY/REPEAT_PERIOD out of range");
    end

    logic [BTN_NUM-1:0] sync1;
    logic [BTN_NUM-1:0] raw;
    logic [BTN_NUM-1:0] level_q;
    logic [BTN_NUM-1:0] press_q;
    logic [BTN_NUM-1:0] release_q;
    logic [BTN_NUM-1:0] accept;
    logic [BTN_NUM-1:0] rep_fire;
    logic [CNT_W-1:0]   cnt [BTN_NUM];

    // Inversion happens at the first flop so everything downstream is active-high.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            sync1 <= '0;
            raw   <= '0;
        end else begin
            sync1 <= ~btn_n_i;
            raw   <= sync1;
        end
    end

    always_comb begin
        accept = '0;
        for (int unsigned k = 0; k < BTN_NUM; k++) begin
            accept[k] = (raw[k] != level_q[k]) && (cnt[k] == CNT_LAST);
        end
    end

    always_ff @(posedge clk100_i) begin
        for (int unsigned k = 0; k < BTN_NUM; k++) begin
            if (rst_i || (raw[k] == level_q[k]) || accept[k]) begin
                cnt[k] <= '0;
            end else begin
                cnt[k] <= cnt[k] + CNT_W'(1);
            end
        end
    end

    // Strobes are registered on the same edge that flips the level.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            level_q   <= level_q ^ accept;
            press_q   <= (accept & raw) | rep_fire;
            release_q <= accept & ~raw;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [26:0] REP_LAST   = 27'(REPEAT_DELAY - 1);
    localparam logic [26:0] REP_RELOAD = 27'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [26:0] rep [BTN_NUM];

    // A repeat is suppressed on the edge a release is accepted so strobes never overlap.
    always_comb begin
        rep_fire = '0;
        for (int unsigned k = 0; k < BTN_NUM; k++) begin
            rep_fire[k] = level_q[k] && !accept[k] && (rep[k] == REP_LAST);
        end
    end

    always_ff @(posedge clk100_i) begin
        for (int unsigned k = 0; k < BTN_NUM; k++) begin
            if (rst_i || !level_q[k]) begin
                rep[k] <= '0;
            end else if (rep_fire[k]) begin
                rep[k] <= REP_RELOAD;
            end else begin
                rep[k] <= rep[k] + 27'(1);
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a time-stamped scoreboard of expected strobes.
// Define BTN_AUTOREPEAT_EN here as for the RTL to expect auto-repeat strobes.
module tb_btn_conditioner;

    localparam int DEB = 8;
    localparam int LAT = DEB + 2;
    localparam int RDELAY = 20;
    localparam int RPERIOD = 5;

    logic       clk100_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [2:0] btn_n_i = 3'b111;
    logic [2:0] level_o;
    logic [2:0] press_o;
    logic [2:0] release_o;

    typedef struct {
        int         at;
        logic [2:0] p;
        logic [2:0] r;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [2:0] exp_level = 3'b000;

    btn_conditioner #(
        .BTN_NUM(3),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(4),
        .REPEAT_DELAY(RDELAY),
        .REPEAT_PERIOD(RPERIOD)
    ) dut (
        .clk100_i(clk100_i),
        .rst_i(rst_i),
        .btn_n_i(btn_n_i),
        .level_o(level_o),
        .press_o(press_o),
        .release_o(release_o)
    );

    always #5 clk100_i = ~clk100_i;

    task automatic push_ev(input int at, input logic [2:0] p, input logic [2:0] r);
        int  i;
        ev_t e;
        i = 0;
        while (i < q.size() && q[i].at < at) i++;
        if (i < q.size() && q[i].at == at) begin
            q[i].p = q[i].p | p;
            q[i].r = q[i].r | r;
        end else begin
            e.at = at;
            e.p  = p;
            e.r  = r;
            q.insert(i, e);
        end
    endtask

    task automatic tick();
        logic       rst_edge;
        logic [2:0] exp_p;
        logic [2:0] exp_r;
        rst_edge = rst_i;
        @(posedge clk100_i);
        cyc++;
        #1;
        exp_p = 3'b000;
        exp_r = 3'b000;
        if (rst_edge) begin
            q.delete();
            exp_level = 3'b000;
        end else if (q.size() > 0 && q[0].at == cyc) begin
            exp_p     = q[0].p;
            exp_r     = q[0].r;
            exp_level = (exp_level | exp_p) & ~exp_r;
            void'(q.pop_front());
        end
        checks++;
        assert (level_o === exp_level) else begin
            failures++;
            $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, level_o, exp_level);
        end
        checks++;
        assert (press_o === exp_p) else begin
            failures++;
            $error("FAIL press cyc=%0d observed=%b expected=%b", cyc, press_o, exp_p);
        end
        checks++;
        assert (release_o === exp_r) else begin
            failures++;
            $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, release_o, exp_r);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int c;

        // Reset state
        ticks(3);
        rst_i = 1'b0;
        ticks(3);

        // Clean press then release on channel 1
        btn_n_i[1] = 1'b0;
        push_ev(cyc + LAT, 3'b010, 3'b000);
        ticks(40);
        btn_n_i[1] = 1'b1;
        push_ev(cyc + LAT, 3'b000, 3'b010);
        ticks(15);

        // Bounce on channel 0, then a stable low
        for (int i = 0; i < 10; i++) begin
            btn_n_i[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            ticks(3);
        end
        btn_n_i[0] = 1'b0;
        push_ev(cyc + LAT, 3'b001, 3'b000);
        ticks(20);
        btn_n_i[0] = 1'b1;
        push_ev(cyc + LAT, 3'b000, 3'b001);
        ticks(15);

        // Glitch one cycle too short on channel 2
        btn_n_i[2] = 1'b0;
        ticks(DEB - 1);
        btn_n_i[2] = 1'b1;
        ticks(15);

        // Reset mid-count with channel 1 held through it
        btn_n_i[1] = 1'b0;
        ticks(7);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        push_ev(cyc + LAT, 3'b010, 3'b000);
        ticks(15);
        btn_n_i[1] = 1'b1;
        push_ev(cyc + LAT, 3'b000, 3'b010);
        ticks(15);

        // All three together
        btn_n_i = 3'b000;
        push_ev(cyc + LAT, 3'b111, 3'b000);
        ticks(20);
        btn_n_i = 3'b111;
        push_ev(cyc + LAT, 3'b000, 3'b111);
        ticks(15);

        // Long hold on channel 0
        btn_n_i[0] = 1'b0;
        c = cyc;
        push_ev(c + LAT, 3'b001, 3'b000);
`ifdef BTN_AUTOREPEAT_EN
        for (int t = c + LAT + RDELAY; t < c + 50 + LAT; t += RPERIOD) begin
            push_ev(t, 3'b001, 3'b000);
        end
`endif
        ticks(50);
        btn_n_i[0] = 1'b1;
        push_ev(cyc + LAT, 3'b000, 3'b001);
        ticks(25);

        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
